// File: rtl/stoplight_pkg.sv
// Shared encodings for the stoplight monitor: RGB bus codes, phase states,
// fault causes and the nominal dwell times.
package stoplight_pkg;

    localparam logic [2:0] GREEN_RGB  = 3'b010;
    localparam logic [2:0] YELLOW_RGB = 3'b110;
    localparam logic [2:0] RED_RGB    = 3'b100;
    localparam logic [2:0] OFF_RGB    = 3'b000;

    typedef enum logic [2:0] {
        PH_OFF    = 3'd0,
        PH_RED    = 3'd1,
        PH_GREEN  = 3'd2,
        PH_YELLOW = 3'd3,
        PH_FAULT  = 3'd7
    } phase_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_INVALID = 2'b10;

    localparam int DEF_EXP_GREEN  = 31;
    localparam int DEF_EXP_YELLOW = 4;
    localparam int DEF_EXP_RED    = 21;
    localparam int DEF_TOL        = 1;

    // True when a measured dwell lies outside exp_v +/- tol.
    function automatic logic dwell_off(input logic [5:0] dwell, input int exp_v, input int tol);
        int d;
        d = int'(dwell) - exp_v;
        return (d > tol) || (-d > tol);
    endfunction

endpackage

// File: rtl/stoplight_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// the first tick appears TICK_DIV cycles after Reset is released.
module stoplight_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic Clock,
    input  logic Reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/stoplight_monitor.sv
// Passive stoplight RGB observer: phase tracking, dwell capture, loop count.
// Optional dwell tolerance checking is built when STOPLIGHT_MON_TIMING_CHECK_EN is defined.
//
//   state     | meaning
//   PH_OFF    | lights dark (reset / after any colour->OFF)
//   PH_RED    | red showing
//   PH_GREEN  | green showing
//   PH_YELLOW | yellow showing
//   PH_FAULT  | illegal order or invalid code seen; held until Reset
module stoplight_monitor
    import stoplight_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int          EXP_GREEN  = DEF_EXP_GREEN,
    parameter int          EXP_YELLOW = DEF_EXP_YELLOW,
    parameter int          EXP_RED    = DEF_EXP_RED,
    parameter int          TOL        = DEF_TOL
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] RGB,
    output logic [2:0] phase,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [5:0] dur_red,
    output logic [5:0] dur_green,
    output logic [5:0] dur_yellow,
    output logic       dur_valid,
    output logic [7:0] cycles,
    output logic [2:0] timing_err
);

    logic [2:0] rgb_q;
    phase_t     phase_q, phase_nxt;
    logic [1:0] fc_nxt;
    logic [5:0] dwell_q;
    logic       tick;
    logic       changed, capture;
    logic       rg_seen_q, gy_seen_q;

    stoplight_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clock (Clock),
        .Reset (Reset),
        .tick  (tick)
    );

    always_comb begin
        phase_nxt = phase_q;
        fc_nxt    = FC_NONE;
        if (phase_q != PH_FAULT) begin
            case (rgb_q)
                OFF_RGB: phase_nxt = PH_OFF;
                RED_RGB: begin
                    if (phase_q == PH_OFF || phase_q == PH_YELLOW) phase_nxt = PH_RED;
                    else if (phase_q != PH_RED) begin
                        phase_nxt = PH_FAULT;
                        fc_nxt    = FC_ILLEGAL;
                    end
                end
                GREEN_RGB: begin
                    if (phase_q == PH_RED) phase_nxt = PH_GREEN;
                    else if (phase_q != PH_GREEN) begin
                        phase_nxt = PH_FAULT;
                        fc_nxt    = FC_ILLEGAL;
                    end
                end
                YELLOW_RGB: begin
                    if (phase_q == PH_GREEN) phase_nxt = PH_YELLOW;
                    else if (phase_q != PH_YELLOW) begin
                        phase_nxt = PH_FAULT;
                        fc_nxt    = FC_ILLEGAL;
                    end
                end
                default: begin
                    phase_nxt = PH_FAULT;
                    fc_nxt    = FC_INVALID;
                end
            endcase
        end
        changed = (phase_nxt != phase_q);
        capture = changed && (phase_nxt != PH_FAULT) &&
                  (phase_q == PH_RED || phase_q == PH_GREEN || phase_q == PH_YELLOW);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rgb_q      <= OFF_RGB;
            phase_q    <= PH_OFF;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            dwell_q    <= '0;
            dur_red    <= '0;
            dur_green  <= '0;
            dur_yellow <= '0;
            dur_valid  <= 1'b0;
        end else begin
            rgb_q     <= RGB;
            phase_q   <= phase_nxt;
            dur_valid <= capture;
            if (phase_nxt == PH_FAULT && phase_q != PH_FAULT) begin
                fault      <= 1'b1;
                fault_code <= fc_nxt;
            end
            // A tick landing on the change edge is dropped, not carried over.
            if (changed)                        dwell_q <= '0;
            else if (tick && dwell_q != 6'd63)  dwell_q <= dwell_q + 6'd1;
            if (capture) begin
                case (phase_q)
                    PH_RED:    dur_red    <= dwell_q;
                    PH_GREEN:  dur_green  <= dwell_q;
                    PH_YELLOW: dur_yellow <= dwell_q;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rg_seen_q <= 1'b0;
            gy_seen_q <= 1'b0;
            cycles    <= '0;
        end else if (changed && phase_nxt == PH_OFF) begin
            rg_seen_q <= 1'b0;
            gy_seen_q <= 1'b0;
        end else if (phase_q == PH_RED && phase_nxt == PH_GREEN) begin
            rg_seen_q <= 1'b1;
            gy_seen_q <= 1'b0;
        end else if (phase_q == PH_GREEN && phase_nxt == PH_YELLOW) begin
            gy_seen_q <= rg_seen_q;
        end else if (phase_q == PH_YELLOW && phase_nxt == PH_RED) begin
            if (gy_seen_q) cycles <= cycles + 8'd1;
            rg_seen_q <= 1'b0;
            gy_seen_q <= 1'b0;
        end
    end

    assign phase = phase_q;

`ifdef STOPLIGHT_MON_TIMING_CHECK_EN
    logic [2:0] te_q, te_now;

    always_comb begin
        te_now = 3'b000;
        if (capture) begin
            case (phase_q)
                PH_RED:    te_now[0] = dwell_off(dwell_q, EXP_RED, TOL);
                PH_GREEN:  te_now[1] = dwell_off(dwell_q, EXP_GREEN, TOL);
                PH_YELLOW: te_now[2] = dwell_off(dwell_q, EXP_YELLOW, TOL);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) te_q <= 3'b000;
        else       te_q <= te_q | te_now;
    end

    assign timing_err = te_q;
`else
    assign timing_err = 3'b000;
`endif

endmodule

// File: tb/tb_stoplight_monitor.sv
// Scoreboard bench for stoplight_monitor: randomized RGB sequences, reference
// model of legal order, dwell windows and loop counting.
module tb_stoplight_monitor;

    localparam int TD    = 4;
    localparam int EXP_R = 21;
    localparam int EXP_G = 31;
    localparam int EXP_Y = 4;
    localparam int TOL_T = 1;

    localparam logic [2:0] C_OFF = 3'b000;
    localparam logic [2:0] C_RED = 3'b100;
    localparam logic [2:0] C_GRN = 3'b010;
    localparam logic [2:0] C_YEL = 3'b110;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] RGB   = 3'b000;
    logic [2:0] phase;
    logic       fault;
    logic [1:0] fault_code;
    logic [5:0] dur_red, dur_green, dur_yellow;
    logic       dur_valid;
    logic [7:0] cycles;
    logic [2:0] timing_err;

    stoplight_monitor #(
        .TICK_DIV(TD), .EXP_GREEN(EXP_G), .EXP_YELLOW(EXP_Y), .EXP_RED(EXP_R), .TOL(TOL_T)
    ) dut (
        .Clock(Clock), .Reset(Reset), .RGB(RGB), .phase(phase), .fault(fault),
        .fault_code(fault_code), .dur_red(dur_red), .dur_green(dur_green),
        .dur_yellow(dur_yellow), .dur_valid(dur_valid), .cycles(cycles),
        .timing_err(timing_err)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int       ph;
        bit       flt;
        int       fc;
        int       cyc_exp;
        int       which;
        int       lo;
        int       hi;
        bit [2:0] must;
        bit [2:0] may;
        int       stamp;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    // reference model state (phase numbering: 0 off, 1 red, 2 green, 3 yellow, 7 fault)
    int       m_ph, m_fc, m_cycles, m_hold;
    bit       m_flt;
    bit [2:0] m_must, m_may;
    int       hist[$];

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int colour_of(input logic [2:0] c);
        case (c)
            C_OFF:   return 0;
            C_RED:   return 1;
            C_GRN:   return 2;
            C_YEL:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] code_of(input int p);
        case (p)
            1:       return C_RED;
            2:       return C_GRN;
            3:       return C_YEL;
            default: return C_OFF;
        endcase
    endfunction

    function automatic bit legal(input int from, input int to);
        return (to == 0) || (from == 0 && to == 1) || (from == 1 && to == 2) ||
               (from == 2 && to == 3) || (from == 3 && to == 1);
    endfunction

    function automatic bit deviates(input int v, input int e);
        return (v - e > TOL_T) || (e - v > TOL_T);
    endfunction

    // Apply one RGB code for n_ticks tick periods and predict the visible reaction.
    task automatic drive(input logic [2:0] code, input int n_ticks);
        int   p, nxt, ex;
        exp_t e;
        @(negedge Clock);
        RGB = code;
        p = colour_of(code);
        if (m_ph != 7 && p != m_ph) begin
            if (p < 0) begin
                nxt = 7; m_flt = 1'b1; m_fc = 2;
            end else if (legal(m_ph, p)) begin
                nxt = p;
            end else begin
                nxt = 7; m_flt = 1'b1; m_fc = 1;
            end
            e.which = 0; e.lo = 0; e.hi = 0;
            if (nxt != 7 && m_ph != 0) begin
                e.which = m_ph;
                e.lo = (m_hold - 1 > 63) ? 63 : ((m_hold > 0) ? m_hold - 1 : 0);
                e.hi = (m_hold > 63) ? 63 : m_hold;
`ifdef STOPLIGHT_MON_TIMING_CHECK_EN
                ex = (m_ph == 1) ? EXP_R : (m_ph == 2) ? EXP_G : EXP_Y;
                if (deviates(e.lo, ex) && deviates(e.hi, ex)) m_must[m_ph-1] = 1'b1;
                if (deviates(e.lo, ex) || deviates(e.hi, ex)) m_may[m_ph-1]  = 1'b1;
`else
                ex = 0;
`endif
            end
            if (nxt == 0) hist.delete();
            else if (nxt != 7) begin
                hist.push_back(nxt);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4 && hist[0] == 1 && hist[1] == 2 && hist[2] == 3 && hist[3] == 1)
                    m_cycles = (m_cycles + 1) % 256;
            end
            m_ph = nxt;
            m_hold = 0;
            e.ph = nxt; e.flt = m_flt; e.fc = m_fc; e.cyc_exp = m_cycles;
            e.must = m_must; e.may = m_may; e.stamp = cyc;
            sb.push_back(e);
        end
        repeat (n_ticks * TD - 1) @(negedge Clock);
        m_hold += n_ticks;
    endtask

    task automatic rand_loop();
        drive(C_GRN, $urandom_range(1, 3));
        drive(C_YEL, $urandom_range(1, 3));
        drive(C_RED, $urandom_range(1, 3));
    endtask

    // monitor: every phase change must match the oldest prediction
    int   prev_ph = 0;
    bit   mon_en = 1'b0;
    int   dv_count = 0;
    exp_t mon_e;
    int   mon_d;

    always @(negedge Clock) begin
        if (mon_en) begin
            if (int'(phase) != prev_ph) begin
                if (sb.size() == 0) begin
                    chk("unexpected_phase_change", 1'b0, phase, prev_ph);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency", (cyc - mon_e.stamp) == 2, cyc - mon_e.stamp, 2);
                    chk("phase", int'(phase) == mon_e.ph, phase, mon_e.ph);
                    chk("fault", fault == mon_e.flt, fault, mon_e.flt);
                    chk("fault_code", int'(fault_code) == mon_e.fc, fault_code, mon_e.fc);
                    chk("cycles", int'(cycles) == mon_e.cyc_exp, cycles, mon_e.cyc_exp);
                    chk("dur_valid", dur_valid == (mon_e.which != 0), dur_valid, mon_e.which != 0);
                    if (mon_e.which != 0) begin
                        mon_d = (mon_e.which == 1) ? int'(dur_red) :
                                (mon_e.which == 2) ? int'(dur_green) : int'(dur_yellow);
                        chk("dur_window", mon_d >= mon_e.lo && mon_d <= mon_e.hi, mon_d, mon_e.hi);
                    end
                    chk("timing_err", ((timing_err & mon_e.must) == mon_e.must) &&
                                      ((timing_err & ~mon_e.may) == 3'b000), timing_err, mon_e.must);
                end
                prev_ph = int'(phase);
            end else if (dur_valid) begin
                chk("spurious_dur_valid", 1'b0, dur_valid, 0);
            end
            if (dur_valid) dv_count++;
        end
    end

    task automatic do_reset();
        @(negedge Clock);
        chk("sb_drained", sb.size() == 0, sb.size(), 0);
        mon_en = 1'b0;
        Reset = 1'b1;
        RGB = C_OFF;
        @(negedge Clock);
        chk("rst_phase", phase == 3'd0, phase, 0);
        chk("rst_fault", fault == 1'b0 && fault_code == 2'b00, {fault, fault_code}, 0);
        chk("rst_dur", dur_red == 0 && dur_green == 0 && dur_yellow == 0,
            {dur_red, dur_green, dur_yellow}, 0);
        chk("rst_dur_valid", dur_valid == 1'b0, dur_valid, 0);
        chk("rst_cycles", cycles == 8'd0, cycles, 0);
        chk("rst_timing_err", timing_err == 3'b000, timing_err, 0);
        @(negedge Clock);
        Reset = 1'b0;
        m_ph = 0; m_fc = 0; m_flt = 1'b0; m_cycles = 0; m_hold = 0;
        m_must = 3'b000; m_may = 3'b000;
        hist.delete();
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            chk("first_tick", dut.u_tick.tick == (k == 4), dut.u_tick.tick, k == 4);
        end
        #1;
        prev_ph = 0;
        dv_count = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d, required 0", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, nxt_p;
        do_reset();

        // nominal loop at the expected dwells
        drive(C_OFF, 2);
        drive(C_RED, EXP_R);
        drive(C_GRN, EXP_G);
        drive(C_YEL, EXP_Y);
        drive(C_RED, 3);
        chk("nominal_cycles", int'(cycles) == m_cycles && cycles == 8'd1, cycles, 1);
        chk("nominal_dv_pulses", dv_count == 3, dv_count, 3);
        chk("nominal_no_fault", fault == 1'b0, fault, 0);

        // GREEN -> RED is illegal; FAULT then ignores legal codes
        drive(C_GRN, 3);
        drive(C_RED, 2);
        drive(C_GRN, 2);
        drive(C_YEL, 2);
        drive(C_OFF, 2);
        chk("fault_absorbing", phase == 3'd7 && fault_code == 2'b01, phase, 7);

        // invalid code while RED
        do_reset();
        drive(C_RED, 2);
        drive(3'b101, 2);
        drive(C_RED, 2);
        chk("invalid_code", phase == 3'd7 && fault_code == 2'b10, {phase, fault_code}, 6'b111_10);

        // GREEN held far past the 6-bit range
        do_reset();
        drive(C_RED, EXP_R);
        drive(C_GRN, 80);
        drive(C_YEL, EXP_Y);
        drive(C_RED, 2);
        chk("green_saturated", dur_green == 6'd63, dur_green, 63);
`ifdef STOPLIGHT_MON_TIMING_CHECK_EN
        chk("sat_timing_err", timing_err == 3'b010, timing_err, 3'b010);
`else
        chk("sat_timing_err", timing_err == 3'b000, timing_err, 3'b000);
`endif

        // reset in the middle of GREEN after three loops
        do_reset();
        drive(C_RED, 1);
        repeat (3) rand_loop();
        drive(C_GRN, 2);
        chk("pre_reset_cycles", cycles == 8'd3, cycles, 3);
        do_reset();

        // 256 loops wrap the counter
        drive(C_RED, 1);
        repeat (256) rand_loop();
        chk("cycles_wrap", int'(cycles) == m_cycles && cycles == 8'd0, cycles, m_cycles);

        // OFF in the middle of a loop discards the partial loop
        drive(C_GRN, 2);
        drive(C_YEL, 1);
        drive(C_OFF, 1);
        drive(C_RED, 2);
        drive(C_OFF, 1);
        drive(C_RED, 2);
        chk("partial_loop", int'(cycles) == m_cycles && fault == 1'b0, cycles, m_cycles);

        // random legal walk with OFF interruptions
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            case (m_ph)
                0:       nxt_p = 1;
                1:       nxt_p = 2;
                2:       nxt_p = 3;
                default: nxt_p = 1;
            endcase
            if (r < 70)      drive(code_of(nxt_p), $urandom_range(1, 3));
            else if (r < 85) drive(C_OFF, $urandom_range(1, 2));
            else             drive(code_of(m_ph), $urandom_range(1, 2));
        end
        chk("walk_cycles", int'(cycles) == m_cycles, cycles, m_cycles);
        chk("walk_no_fault", fault == 1'b0 && phase == 3'(m_ph), phase, m_ph);

        repeat (4) @(negedge Clock);
        chk("sb_final_drained", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stoplight_monitor.md
# stoplight_monitor

Passive observer for the stoplight RGB output bus. Samples the 3-bit RGB code and decodes it into a phase. Measures how long each phase lasts in 1 Hz ticks and checks that the phases follow the legal order. Sits beside the stoplight controller on the board, or in the bench as a checker, and drives status LEDs and debug registers.

## Interface
- TICK_DIV, 100_000_000: number of Clock cycles per internal tick (1 Hz on the board; small values in simulation).
- EXP_GREEN, 31: expected GREEN dwell, in ticks.
- EXP_YELLOW, 4: expected YELLOW dwell, in ticks.
- EXP_RED, 21: expected RED dwell, in ticks.
- TOL, 1: allowed dwell deviation, in ticks, before a timing error is flagged.
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- RGB  in  3  observed light code: 010 GREEN, 110 YELLOW, 100 RED, 000 OFF; any other code is INVALID.
- phase  out  3  current monitor state: 0 OFF, 1 RED, 2 GREEN, 3 YELLOW, 7 FAULT.
- fault  out  1  sticky fault flag.
- fault_code  out  2  first fault cause: 01 illegal transition, 10 invalid code; 00 means no fault.
- dur_red, dur_green, dur_yellow  out  6 each  last completed dwell of each phase, in ticks.
- dur_valid  out  1  one-cycle pulse when any dur_* register updates.
- cycles  out  8  count of completed RED→GREEN→YELLOW→RED loops; wraps at 255 back to 0.
- timing_err  out  3  sticky per-phase deviation flags, bit order {yellow, green, red}.

## Operation
- Input stage: RGB is registered into rgb_q; decode and state logic operate on rgb_q.
- Tick generator: a mod-TICK_DIV counter. The tick pulses for one cycle when the count reaches TICK_DIV-1.
- Dwell counter (6 bits):
  - increments on each tick;
  - saturates at 63;
  - cleared on every decoded phase change; a tick coinciding with a change is dropped.
- Phase FSM (states OFF, RED, GREEN, YELLOW, FAULT):
  - Legal transitions: OFF→RED, RED→GREEN, GREEN→YELLOW, YELLOW→RED.
  - Any colour state →OFF is legal; the cycle-loop tracking is discarded.
  - Code unchanged: the FSM stays in its current state.
  - Any other colour change: go to FAULT, fault=1, fault_code=01.
  - INVALID code in any non-FAULT state: go to FAULT, fault_code=10.
  - FAULT is absorbing until Reset.
  - When two causes would apply, only the first fault is recorded.
- Duration capture, on a legal transition out of RED, GREEN or YELLOW:
  - the dwell count (saturated) is written into the matching dur_* register;
  - dur_valid pulses for one cycle.
  - The dwell of OFF is not captured.
  - A RED dwell that began from OFF is captured normally.
- Loop counter: `cycles` increments on a YELLOW→RED transition, provided the preceding RED→GREEN and GREEN→YELLOW transitions were seen since the last OFF or Reset.
- Reset, including mid-operation: phase=0 (OFF), fault=0, fault_code=00, all dur_*=0, dur_valid=0, cycles=0, timing_err=000. The tick counter and the dwell counter are also cleared.

## Timing
- RGB change to phase update: 2 cycles (1 cycle input register, then 1 cycle state register).
- dur_*, dur_valid and cycles update on the same edge as phase.
- First tick occurs TICK_DIV cycles after Reset deasserts, then once every TICK_DIV cycles.
- Measured dwell is the number of ticks seen. Because the controller's tick and this tick are unaligned, a correct dwell reads EXP or EXP-1; TOL covers this.
- All outputs are registered; there is no combinational path from RGB to any output.

## Configuration
- STOPLIGHT_MON_TIMING_CHECK_EN defined:
  - on each capture, if |dwell − EXP_x| > TOL, the matching timing_err bit is set;
  - the bit sets on the same edge as dur_valid and stays set until Reset;
  - a timing error does not change phase or fault.
- Macro undefined: the comparison logic is not built; timing_err is tied to 000.

## Structure
- Package stoplight_pkg holds:
  - RGB code localparams (GREEN_RGB, YELLOW_RGB, RED_RGB, OFF_RGB);
  - the phase state encoding;
  - the fault_code values;
  - the default EXP_* durations.
- The controller reuses the same RGB localparams.
- One sub-module, stoplight_tick_gen (parameter TICK_DIV, ports Clock, Reset, tick). The bench instantiates it with TICK_DIV=4.

## Test plan
- TICK_DIV=4. Drive RGB OFF→RED(21 ticks)→GREEN(31)→YELLOW(4)→RED → phase sequence 0,1,2,3,1; dur_red=21 (±1), dur_green=31 (±1), dur_yellow=4 (±1); 3 dur_valid pulses; cycles=1; fault=0.
- From GREEN, drive RED directly → 2 cycles later phase=7, fault=1, fault_code=01; later legal codes leave phase at 7.
- Drive RGB=101 while in RED → phase=7, fault_code=10.
- Hold GREEN for 80 ticks, then YELLOW → dur_green=63 (saturated). With STOPLIGHT_MON_TIMING_CHECK_EN defined, timing_err=010.
- Assert Reset mid-GREEN with cycles=3 → next cycle all outputs at reset values. First tick occurs 4 cycles after Reset deasserts.
- Run 256 full loops → cycles wraps to 0. RED→OFF→RED mid-loop → loop tracking discarded, cycles not incremented for the partial loop, no fault.
